// File: rtl/alu_div.sv
// Multi-cycle restoring divider for DIV/IDIV (8/16/32-bit), one quotient bit per clock.
// Optional AAM support is compiled in when ALU_DIV_AAM_EN is defined.
module alu_div (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic        isize,
    input  logic        opsize,
    input  logic        aam,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    input  logic [11:0] flags,
    output logic        busy,
    output logic        done,
    output logic        div_err,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic [11:0] flags_o
);

    typedef enum logic [2:0] {IDLE, PREP, LOOP, FIX, DONE, ERR} state_t;
    typedef enum logic [1:0] {W8, W16, W32} width_t;

    state_t      state;
    width_t      width_r;
    logic        sgn_r;
    logic [63:0] dvd_r;
    logic [31:0] dvs_r;
    logic [4:0]  cnt;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_mag_r;
    logic        early_err_r;
`ifdef ALU_DIV_AAM_EN
    logic        aam_r;
`else
    logic        unused_aam;
    assign unused_aam = aam;
`endif

    logic [5:0]  n_bits;
    logic [31:0] mask;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [63:0] dvd_ext;
    logic [31:0] dvs_ext;
    logic [63:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [63:0] hi;
    logic [31:0] lo;

    // Operand decode works on the latched copies, so input changes mid-operation are harmless.
    always_comb begin
        n_bits  = 6'd32;
        mask    = 32'hFFFF_FFFF;
        dvd_neg = sgn_r & dvd_r[63];
        dvs_neg = sgn_r & dvs_r[31];
        dvd_ext = dvd_r;
        dvs_ext = dvs_r;
        case (width_r)
            W8: begin
                n_bits  = 6'd8;
                mask    = 32'h0000_00FF;
                dvd_neg = sgn_r & dvd_r[15];
                dvs_neg = sgn_r & dvs_r[7];
                dvd_ext = {{48{dvd_neg}}, dvd_r[15:0]};
                dvs_ext = {{24{dvs_neg}}, dvs_r[7:0]};
            end
            W16: begin
                n_bits  = 6'd16;
                mask    = 32'h0000_FFFF;
                dvd_neg = sgn_r & dvd_r[31];
                dvs_neg = sgn_r & dvs_r[15];
                dvd_ext = {{32{dvd_neg}}, dvd_r[31:0]};
                dvs_ext = {{16{dvs_neg}}, dvs_r[15:0]};
            end
            default: ;
        endcase
        dvd_mag = dvd_neg ? (64'd0 - dvd_ext) : dvd_ext;
        dvs_mag = dvs_neg ? (32'd0 - dvs_ext) : dvs_ext;
        hi      = dvd_mag >> n_bits;
        lo      = dvd_mag[31:0] & mask;
`ifdef ALU_DIV_AAM_EN
        // AAM divides AL alone by imm8, so the high half is forced to zero.
        if (aam_r) begin
            dvd_neg = 1'b0;
            dvs_neg = 1'b0;
            hi      = 64'd0;
            lo      = {24'd0, dvd_r[7:0]};
            dvs_mag = {24'd0, dvs_r[7:0]};
        end
`endif
    end

    logic [32:0] trial;
    logic [31:0] diff;
    logic        take;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_out;
    logic [31:0] r_out;
    logic [31:0] limit;
    logic        neg_q;
    logic        range_err;
    logic [11:0] aam_flags;
    logic [7:0]  new_al;

    always_comb begin
        trial     = {rem_r, quo_r[31]};
        diff      = trial[31:0] - dvs_mag_r;
        take      = (trial >= {1'b0, dvs_mag_r});
        q_mag     = quo_r & mask;
        r_mag     = rem_r & mask;
        neg_q     = dvd_neg ^ dvs_neg;
        q_out     = neg_q ? ((32'd0 - q_mag) & mask) : q_mag;
        r_out     = dvd_neg ? ((32'd0 - r_mag) & mask) : r_mag;
        limit     = 32'd1 << (n_bits - 6'd1);
        range_err = sgn_r & (neg_q ? (q_mag > limit) : (q_mag >= limit));
        new_al    = r_mag[7:0];
        aam_flags = flags;
        aam_flags[7]  = new_al[7];
        aam_flags[6]  = (new_al == 8'd0);
        aam_flags[2]  = ~^new_al;
        aam_flags[11] = 1'b0;
        aam_flags[4]  = 1'b0;
        aam_flags[0]  = 1'b0;
    end

    // Control FSM: done/div_err are set on the edge that leaves FIX, so they are high for the DONE/ERR cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_err     <= 1'b0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            flags_o     <= 12'h002;
            width_r     <= W8;
            sgn_r       <= 1'b0;
            dvd_r       <= 64'd0;
            dvs_r       <= 32'd0;
            cnt         <= 5'd0;
            rem_r       <= 32'd0;
            quo_r       <= 32'd0;
            dvs_mag_r   <= 32'd0;
            early_err_r <= 1'b0;
`ifdef ALU_DIV_AAM_EN
            aam_r       <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            div_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        state   <= PREP;
                        dvd_r   <= dividend;
                        dvs_r   <= divisor;
                        width_r <= !isize ? W8 : (opsize ? W32 : W16);
                        sgn_r   <= signed_op;
`ifdef ALU_DIV_AAM_EN
                        aam_r   <= aam;
                        if (aam) begin
                            width_r <= W8;
                            sgn_r   <= 1'b0;
                        end
`endif
                    end
                end
                PREP: begin
                    rem_r       <= hi[31:0];
                    quo_r       <= lo << (6'd32 - n_bits);
                    dvs_mag_r   <= dvs_mag;
                    cnt         <= 5'(n_bits - 6'd1);
                    early_err_r <= (dvs_mag == 32'd0) || (hi >= {32'd0, dvs_mag});
                    // Early errors skip the loop but still pass through FIX to keep a 2-edge latency.
                    if ((dvs_mag == 32'd0) || (hi >= {32'd0, dvs_mag}))
                        state <= FIX;
                    else
                        state <= LOOP;
                end
                LOOP: begin
                    rem_r <= take ? diff : trial[31:0];
                    quo_r <= {quo_r[30:0], take};
                    if (cnt == 5'd0)
                        state <= FIX;
                    else
                        cnt <= cnt - 5'd1;
                end
                FIX: begin
                    done    <= 1'b1;
                    flags_o <= flags;
                    if (early_err_r || range_err) begin
                        state   <= ERR;
                        div_err <= 1'b1;
                    end else begin
                        state     <= DONE;
                        quotient  <= q_out;
                        remainder <= r_out;
`ifdef ALU_DIV_AAM_EN
                        if (aam_r) begin
                            quotient  <= {16'd0, q_mag[7:0], r_mag[7:0]};
                            remainder <= 32'd0;
                            flags_o   <= aam_flags;
                        end
`endif
                    end
                end
                DONE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ALU_DIV_AAM_EN
    logic [11:0] unused_aam_flags;
    assign unused_aam_flags = aam_flags;
`endif

endmodule

// File: tb/tb_alu_div.sv
// Directed testbench for alu_div: DIV/IDIV at all widths, error paths, control behaviour and AAM.
module tb_alu_div;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        signed_op;
    logic        isize;
    logic        opsize;
    logic        aam;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic [11:0] flags;
    logic        busy;
    logic        done;
    logic        div_err;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [11:0] flags_o;

    int tests_run;
    int tests_failed;
    int lat;
    int done_count;

    alu_div dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .signed_op (signed_op),
        .isize     (isize),
        .opsize    (opsize),
        .aam       (aam),
        .dividend  (dividend),
        .divisor   (divisor),
        .flags     (flags),
        .busy      (busy),
        .done      (done),
        .div_err   (div_err),
        .quotient  (quotient),
        .remainder (remainder),
        .flags_o   (flags_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // width: 0=8-bit, 1=16-bit, 2=32-bit; inputs are scrambled after start to prove they were latched
    task automatic applyStimulus(input logic s_op, input logic [1:0] width, input logic aam_v,
                                 input logic [63:0] dvd, input logic [31:0] dvs, output int edges);
        int guard;
        guard = 0;
        @(negedge clock);
        while (busy && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        signed_op = s_op;
        isize     = (width != 2'd0);
        opsize    = (width == 2'd2);
        aam       = aam_v;
        dividend  = dvd;
        divisor   = dvs;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        signed_op = ~s_op;
        isize     = ~isize;
        opsize    = ~opsize;
        aam       = ~aam_v;
        dividend  = ~dvd;
        divisor   = ~dvs;
        edges = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                edges = k;
                break;
            end
        end
        if (edges < 0) checkOutput("done_timeout", done, 1);
    endtask

    task automatic checkResult(input string tag, input logic exp_err, input logic [31:0] exp_q,
                               input logic [31:0] exp_r, input logic [11:0] exp_f,
                               input int exp_lat, input int got_lat);
        checkOutput({tag, "_lat"}, got_lat, exp_lat);
        checkOutput({tag, "_err"}, div_err, exp_err);
        checkOutput({tag, "_q"}, quotient, exp_q);
        checkOutput({tag, "_r"}, remainder, exp_r);
        checkOutput({tag, "_flags"}, flags_o, exp_f);
        checkOutput({tag, "_busy"}, busy, 1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        signed_op    = 1'b0;
        isize        = 1'b0;
        opsize       = 1'b0;
        aam          = 1'b0;
        dividend     = 64'd0;
        divisor      = 32'd0;
        flags        = 12'h8D5;

        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", div_err, 0);
        checkOutput("rst_q", quotient, 0);
        checkOutput("rst_r", remainder, 0);
        checkOutput("rst_flags", flags_o, 12'h002);
        reset_n = 1'b1;

        applyStimulus(0, 2'd0, 0, 64'h0064, 32'h07, lat);
        checkResult("div8", 0, 32'h0E, 32'h02, 12'h8D5, 10, lat);

        applyStimulus(1, 2'd1, 0, 64'hFFFF_FFF9, 32'h0002, lat);
        checkResult("idiv16", 0, 32'hFFFD, 32'hFFFF, 12'h8D5, 18, lat);

        applyStimulus(0, 2'd2, 0, 64'h1234_5678_9ABC_DEF0, 32'h0, lat);
        checkResult("div32_zero", 1, 32'hFFFD, 32'hFFFF, 12'h8D5, 2, lat);

        applyStimulus(0, 2'd0, 0, 64'h0200, 32'h02, lat);
        checkResult("div8_ovf", 1, 32'hFFFD, 32'hFFFF, 12'h8D5, 2, lat);

        applyStimulus(1, 2'd0, 0, 64'hFF80, 32'h01, lat);
        checkResult("idiv8_min", 0, 32'h80, 32'h00, 12'h8D5, 10, lat);

        applyStimulus(1, 2'd0, 0, 64'h0080, 32'h01, lat);
        checkResult("idiv8_ovf", 1, 32'h80, 32'h00, 12'h8D5, 10, lat);

        applyStimulus(1, 2'd0, 0, 64'h0064, 32'hF9, lat);
        checkResult("idiv8_negdvs", 0, 32'hF2, 32'h02, 12'h8D5, 10, lat);

        applyStimulus(1, 2'd1, 0, 64'hFFFF_FF9C, 32'hFFF9, lat);
        checkResult("idiv16_negneg", 0, 32'h000E, 32'hFFFE, 12'h8D5, 18, lat);

        applyStimulus(0, 2'd2, 0, 64'h1_0000_0000, 32'h10, lat);
        checkResult("div32", 0, 32'h1000_0000, 32'h0, 12'h8D5, 34, lat);

        applyStimulus(1, 2'd2, 0, 64'hFFFF_FFFF_FFFF_FFF9, 32'h2, lat);
        checkResult("idiv32", 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 12'h8D5, 34, lat);

        // start held high through the whole operation must produce exactly one completion
        @(negedge clock);
        while (busy) @(negedge clock);
        signed_op  = 1'b0;
        isize      = 1'b0;
        opsize     = 1'b0;
        aam        = 1'b0;
        dividend   = 64'h0064;
        divisor    = 32'h07;
        start      = 1'b1;
        done_count = 0;
        for (int i = 0; i <= 10; i++) begin
            @(posedge clock);
            #1;
            if (done) done_count++;
            if (i == 5) checkOutput("held_busy_mid", busy, 1);
        end
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (done) done_count++;
        end
        checkOutput("held_done_count", done_count, 1);
        checkOutput("held_q", quotient, 32'h0E);

        // reset during loop iteration 5 aborts without a done pulse
        @(negedge clock);
        dividend = 64'h0064;
        divisor  = 32'h07;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_q", quotient, 0);
        @(negedge clock);
        reset_n    = 1'b1;
        done_count = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            #1;
            if (done) done_count++;
        end
        checkOutput("abort_no_done", done_count, 0);

        flags = 12'hFD5;
        applyStimulus(0, 2'd0, 1, 64'h003B, 32'h0A, lat);
`ifdef ALU_DIV_AAM_EN
        checkResult("aam", 0, 32'h0509, 32'h0, 12'h704, 10, lat);
`else
        checkResult("aam_as_div", 0, 32'h05, 32'h09, 12'hFD5, 10, lat);
`endif

        applyStimulus(0, 2'd0, 1, 64'h003B, 32'h00, lat);
`ifdef ALU_DIV_AAM_EN
        checkResult("aam_zero", 1, 32'h0509, 32'h0, 12'hFD5, 2, lat);
`else
        checkResult("aam_zero_as_div", 1, 32'h05, 32'h09, 12'hFD5, 2, lat);
`endif

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
